// File: rtl/cu_prefetch_stream_arbiter.sv
// Shares one downstream command buffer among several prefetch stream engines.
// Each engine's command lines are queued in a private FIFO. Queued lines are
// granted round-robin, one per cycle. Responses are routed back to the engine
// selected by cu_id. Per-stream outstanding counts drive the idle indication.

package cu_prefetch_pkg;

    localparam logic [7:0] PREFETCH_READ_CONTROL_ID = 8'd16;

    typedef struct packed {
        logic        valid;
        logic [7:0]  cu_id;
        logic [7:0]  command;
        logic [31:0] address;
        logic [7:0]  size;
        logic [15:0] tag;
    } CommandBufferLine;

    typedef struct packed {
        logic        valid;
        logic [7:0]  cu_id;
        logic [7:0]  response;
        logic [15:0] tag;
    } ResponseBufferLine;

    typedef struct packed {
        logic alfull;
        logic full;
        logic empty;
    } BufferStatus;

endpackage

module cu_prefetch_stream_arbiter
    import cu_prefetch_pkg::*;
#(
    parameter int         NUM_STREAMS      = 4,
    parameter int         FIFO_DEPTH       = 8,
    parameter logic [7:0] STREAM_ID_BASE   = PREFETCH_READ_CONTROL_ID,
    parameter int         OUTSTANDING_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enabled_in,
    input  CommandBufferLine       stream_command_in    [NUM_STREAMS],
    output BufferStatus            stream_buffer_status [NUM_STREAMS],
    input  BufferStatus            command_buffer_status,
    output CommandBufferLine       command_out,
    input  ResponseBufferLine      response_in,
    output ResponseBufferLine      stream_response_out  [NUM_STREAMS],
    output logic                   arbiter_idle,
    output logic [NUM_STREAMS-1:0] overflow_error,
    output logic                   response_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SID_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    localparam logic [PTR_W-1:0]            PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]            DEPTH_C  = CNT_W'(FIFO_DEPTH);
    // An engine may still issue three lines after it observes alfull.
    localparam logic [CNT_W-1:0]            ALFULL_C = CNT_W'(FIFO_DEPTH - 3);
    localparam logic [OUTSTANDING_BITS-1:0] OUT_ONE  = OUTSTANDING_BITS'(1);
    localparam logic [OUTSTANDING_BITS-1:0] OUT_MAX  = {OUTSTANDING_BITS{1'b1}};
    localparam logic [7:0]                  NUM_C    = 8'(NUM_STREAMS);

    // Stream index reached by stepping 'off' places past 'base', wrapping.
    function automatic logic [SID_W-1:0] rr_index(input logic [SID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_STREAMS) begin
            sum = sum - NUM_STREAMS;
        end else begin
            sum = sum;
        end
        return SID_W'(sum);
    endfunction

    CommandBufferLine              fifo_mem_q    [NUM_STREAMS][FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q      [NUM_STREAMS];
    logic [PTR_W-1:0]              rd_ptr_q      [NUM_STREAMS];
    logic [CNT_W-1:0]              count_q       [NUM_STREAMS];
    logic [CNT_W-1:0]              count_d       [NUM_STREAMS];
    logic [OUTSTANDING_BITS-1:0]   outstanding_q [NUM_STREAMS];
    logic [OUTSTANDING_BITS-1:0]   outstanding_d [NUM_STREAMS];
    logic [SID_W-1:0]              rr_ptr_q;
    logic [SID_W-1:0]              rr_ptr_d;
    logic                          enabled_q;
    logic                          idle_d;
    CommandBufferLine              command_d;
    ResponseBufferLine             response_d    [NUM_STREAMS];

    logic [NUM_STREAMS-1:0]        eligible_s;
    logic [NUM_STREAMS-1:0]        push_s;
    logic [NUM_STREAMS-1:0]        pop_s;
    logic [NUM_STREAMS-1:0]        drop_s;
    logic [NUM_STREAMS-1:0]        rsp_hit_s;
    logic [NUM_STREAMS-1:0]        rsp_dec_s;
    logic [NUM_STREAMS-1:0]        rsp_zero_s;
    logic                          grant_s;
    logic [SID_W-1:0]              grant_idx_s;
    logic [7:0]                    rsp_idx_s;
    logic                          rsp_route_ok_s;
    logic                          rsp_err_s;

    // A stream competes when it holds a line and its counter has headroom.
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            eligible_s[i] = (count_q[i] != '0) && (outstanding_q[i] != OUT_MAX);
        end
    end

    // Round-robin pick: first eligible stream at or after rr_ptr.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = '0;
        for (int off = 0; off < NUM_STREAMS; off++) begin
            if (!grant_s && eligible_s[rr_index(rr_ptr_q, off)]) begin
                grant_s     = 1'b1;
                grant_idx_s = rr_index(rr_ptr_q, off);
            end else begin
                grant_s     = grant_s;
            end
        end
        if (!enabled_q || command_buffer_status.alfull) begin
            grant_s = 1'b0;
        end else begin
            grant_s = grant_s;
        end
        rr_ptr_d = grant_s ? rr_index(grant_idx_s, 1) : rr_ptr_q;
    end

    // Push/pop decisions; a full FIFO popped this cycle still accepts a push.
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            pop_s[i]   = grant_s && (grant_idx_s == SID_W'(i));
            push_s[i]  = stream_command_in[i].valid && ((count_q[i] != DEPTH_C) || pop_s[i]);
            drop_s[i]  = stream_command_in[i].valid && !push_s[i];
            count_d[i] = count_q[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
        end
    end

    // Decode the response target; cu_id below the base wraps to unroutable.
    always_comb begin
        rsp_idx_s      = response_in.cu_id - STREAM_ID_BASE;
        rsp_route_ok_s = response_in.valid && (rsp_idx_s < NUM_C);
        for (int i = 0; i < NUM_STREAMS; i++) begin
            rsp_hit_s[i]     = rsp_route_ok_s && (rsp_idx_s == 8'(i));
            rsp_zero_s[i]    = rsp_hit_s[i] && (outstanding_q[i] == '0);
            rsp_dec_s[i]     = rsp_hit_s[i] && (outstanding_q[i] != '0);
            response_d[i]    = rsp_hit_s[i] ? response_in : '0;
        end
        rsp_err_s = (response_in.valid && !rsp_route_ok_s) || (|rsp_zero_s);
    end

    // Outstanding counters: issue adds one, response removes one, both cancel.
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            case ({pop_s[i], rsp_dec_s[i]})
                2'b10:   outstanding_d[i] = outstanding_q[i] + OUT_ONE;
                2'b01:   outstanding_d[i] = outstanding_q[i] - OUT_ONE;
                default: outstanding_d[i] = outstanding_q[i];
            endcase
        end
    end

    // Granted line leaves with valid forced; idle looks at post-edge state.
    always_comb begin
        command_d = '0;
        if (grant_s) begin
            command_d       = fifo_mem_q[grant_idx_s][rd_ptr_q[grant_idx_s]];
            command_d.valid = 1'b1;
        end else begin
            command_d = '0;
        end
        idle_d = 1'b1;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            idle_d = idle_d && (count_d[i] == '0) && (outstanding_d[i] == '0);
        end
    end

    // FIFO storage; contents need no reset because pointers gate every read.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (push_s[i]) begin
                fifo_mem_q[i][wr_ptr_q[i]] <= stream_command_in[i];
            end
        end
    end

    // Per-stream pointers, counts, counters and status.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (reset) begin
                wr_ptr_q[i]             <= '0;
                rd_ptr_q[i]             <= '0;
                count_q[i]              <= '0;
                outstanding_q[i]        <= '0;
                stream_buffer_status[i] <= '{alfull: 1'b0, full: 1'b0, empty: 1'b1};
                stream_response_out[i]  <= '0;
            end else begin
                if (push_s[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
                if (pop_s[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
                count_q[i]                     <= count_d[i];
                outstanding_q[i]               <= outstanding_d[i];
                stream_buffer_status[i].alfull <= (count_d[i] >= ALFULL_C);
                stream_buffer_status[i].full   <= (count_d[i] == DEPTH_C);
                stream_buffer_status[i].empty  <= (count_d[i] == '0);
                stream_response_out[i]         <= response_d[i];
            end
        end
    end

    // Shared state: enable register, rr pointer, outputs and sticky errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            enabled_q      <= 1'b0;
            rr_ptr_q       <= '0;
            command_out    <= '0;
            arbiter_idle   <= 1'b1;
            overflow_error <= '0;
            response_error <= 1'b0;
        end else begin
            enabled_q      <= enabled_in;
            rr_ptr_q       <= rr_ptr_d;
            command_out    <= command_d;
            arbiter_idle   <= idle_d;
            overflow_error <= overflow_error | drop_s;
            response_error <= response_error | rsp_err_s;
        end
    end

endmodule

// File: tb/tb_cu_prefetch_stream_arbiter.sv
// Bench for cu_prefetch_stream_arbiter: directed scenarios then random traffic,
// all compared every cycle against a queue-based reference model.

module tb_cu_prefetch_stream_arbiter;
    import cu_prefetch_pkg::*;

    localparam int         N    = 4;
    localparam int         D    = 8;
    localparam int         OB   = 8;
    localparam logic [7:0] BASE = PREFETCH_READ_CONTROL_ID;

    logic              clock = 1'b0;
    logic              reset;
    logic              enabled_in;
    CommandBufferLine  sci [N];
    BufferStatus       sbs [N];
    BufferStatus       cbs;
    CommandBufferLine  command_out;
    ResponseBufferLine rsp_in;
    ResponseBufferLine rsp_out [N];
    logic              arbiter_idle;
    logic [N-1:0]      overflow_error;
    logic              response_error;

    cu_prefetch_stream_arbiter #(
        .NUM_STREAMS(N), .FIFO_DEPTH(D), .STREAM_ID_BASE(BASE), .OUTSTANDING_BITS(OB)
    ) dut (
        .clock(clock), .reset(reset), .enabled_in(enabled_in),
        .stream_command_in(sci), .stream_buffer_status(sbs),
        .command_buffer_status(cbs), .command_out(command_out),
        .response_in(rsp_in), .stream_response_out(rsp_out),
        .arbiter_idle(arbiter_idle), .overflow_error(overflow_error),
        .response_error(response_error)
    );

    always #5 clock = ~clock;

    // Reference model state
    CommandBufferLine  mq [N][$];
    int                mout [N];
    int                mrr;
    bit                men;
    bit [N-1:0]        movf;
    bit                merr;
    CommandBufferLine  exp_cmd;
    ResponseBufferLine exp_rsp [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            mout[i]    = 0;
            exp_rsp[i] = '0;
        end
        mrr = 0; men = 1'b0; movf = '0; merr = 1'b0; exp_cmd = '0;
    endtask

    // One clock edge of the arbiter as described by its rules.
    task automatic model_step();
        int g;
        int idx;
        if (reset) begin
            model_reset();
            return;
        end
        g = -1;
        if (men && !cbs.alfull) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mq[(mrr + k) % N].size() > 0 && mout[(mrr + k) % N] < (1 << OB) - 1)
                    g = (mrr + k) % N;
            end
        end
        exp_cmd = '0;
        if (g >= 0) begin
            exp_cmd       = mq[g].pop_front();
            exp_cmd.valid = 1'b1;
            mrr           = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (sci[i].valid) begin
                if (mq[i].size() < D) mq[i].push_back(sci[i]);
                else                  movf[i] = 1'b1;
            end
            exp_rsp[i] = '0;
        end
        if (rsp_in.valid) begin
            idx = int'(rsp_in.cu_id) - int'(BASE);
            if (idx >= 0 && idx < N) begin
                exp_rsp[idx] = rsp_in;
                if (mout[idx] == 0) merr = 1'b1;
                else                mout[idx]--;
            end else begin
                merr = 1'b1;
            end
        end
        if (g >= 0) mout[g]++;
        men = enabled_in;
    endtask

    task automatic check_all();
        bit idle;
        idle = 1'b1;
        check("command_out", 128'(command_out), 128'(exp_cmd));
        for (int i = 0; i < N; i++) begin
            check($sformatf("rsp_out%0d", i), 128'(rsp_out[i]), 128'(exp_rsp[i]));
            check($sformatf("status%0d", i), 128'(sbs[i]),
                  128'({mq[i].size() >= D - 3, mq[i].size() == D, mq[i].size() == 0}));
            if (mq[i].size() != 0 || mout[i] != 0) idle = 1'b0;
        end
        check("idle", 128'(arbiter_idle), 128'(idle));
        check("overflow_error", 128'(overflow_error), 128'(movf));
        check("response_error", 128'(response_error), 128'(merr));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) sci[i] = '0;
        rsp_in = '0;
    endtask

    task automatic push(input int s, input int seq);
        sci[s].valid   = 1'b1;
        sci[s].cu_id   = 8'($urandom);
        sci[s].command = 8'($urandom);
        sci[s].address = $urandom;
        sci[s].size    = 8'($urandom);
        sci[s].tag     = 16'(s * 256 + seq);
    endtask

    task automatic respond(input logic [7:0] id);
        rsp_in.valid    = 1'b1;
        rsp_in.cu_id    = id;
        rsp_in.response = 8'($urandom);
        rsp_in.tag      = 16'($urandom);
    endtask

    int order [$];
    int first_cyc, last_cyc;
    int s;

    initial begin
        reset = 1'b1; enabled_in = 1'b0; cbs = '0;
        clear_inputs();
        model_reset();
        tick(); tick();
        reset = 1'b0;

        // Reset then idle
        tick();
        check("idle_after_reset", 128'(arbiter_idle), 128'(1'b1));

        // Two lines per stream, round-robin back-to-back
        enabled_in = 1'b1;
        for (int i = 0; i < N; i++) push(i, 0);
        tick();
        clear_inputs();
        for (int i = 0; i < N; i++) push(i, 1);
        first_cyc = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            clear_inputs();
            if (command_out.valid) begin
                order.push_back(int'(command_out.tag[15:8]));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        check("grant_count", 128'(order.size()), 128'(8));
        for (int k = 0; k < order.size() && k < 8; k++)
            check($sformatf("order%0d", k), 128'(order[k]), 128'(k % N));
        check("back_to_back", 128'(last_cyc - first_cyc), 128'(7));
        check("idle_busy", 128'(arbiter_idle), 128'(1'b0));

        // Fill stream 2 while disabled
        enabled_in = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            push(2, k);
            tick();
            clear_inputs();
            if (k == 4) check("alfull_at4", 128'(sbs[2].alfull), 128'(1'b0));
            if (k == 5) check("alfull_at5", 128'(sbs[2].alfull), 128'(1'b1));
            if (k == 7) check("full_at7", 128'(sbs[2].full), 128'(1'b0));
            if (k == 8) check("full_at8", 128'(sbs[2].full), 128'(1'b1));
        end
        check("overflow2", 128'(overflow_error), 128'(4'b0100));
        check("full_after_drop", 128'(sbs[2].full), 128'(1'b1));

        // Downstream alfull holds grants off
        enabled_in = 1'b1;
        cbs.alfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("held_cmd", 128'(command_out), 128'(0));
        end
        cbs.alfull = 1'b0;
        tick();
        check("resume_stream", 128'(command_out.tag[15:8]), 128'(2));
        for (int k = 0; k < 9; k++) tick();

        // Routed and unroutable responses
        respond(BASE + 8'd1);
        tick();
        clear_inputs();
        check("rsp1_valid", 128'(rsp_out[1].valid), 128'(1'b1));
        check("rsp1_id", 128'(rsp_out[1].cu_id), 128'(BASE + 8'd1));
        respond(BASE + 8'd7);
        tick();
        clear_inputs();
        check("rsp_err", 128'(response_error), 128'(1'b1));

        // Same-cycle issue and response on stream 0, then drain everything
        push(0, 50);
        tick();
        clear_inputs();
        respond(BASE);
        tick();
        clear_inputs();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 40 && mout[i] > 0; k++) begin
                respond(BASE + 8'(i));
                tick();
                clear_inputs();
            end
        end
        tick();
        check("idle_drained", 128'(arbiter_idle), 128'(1'b1));

        // Random traffic, with a reset in the middle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            clear_inputs();
            reset      = (c == 400);
            enabled_in = ($urandom_range(0, 7) != 0);
            cbs        = '0;
            cbs.alfull = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) < 4) push(i, c % 256);
            if ($urandom_range(0, 2) != 0) begin
                s = int'($urandom_range(0, N - 1));
                if (mout[s] > 0) respond(BASE + 8'(s));
                else if ($urandom_range(0, 19) == 0)
                    respond(8'(int'(BASE) + N + int'($urandom_range(0, 60))));
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
